// File: rtl/comp_hyst_pkg.sv
// Shared types and helpers for the hysteresis comparator.
// Opcode encoding, FSM states and fixed-point alignment helpers.
package comp_hyst_pkg;

    typedef enum logic [1:0] {ST_LOW, ST_ARM_H, ST_HIGH, ST_ARM_L} hyst_state_t;

    typedef enum logic [1:0] {
        GT_OPCODE_REAL = 2'd0,
        GE_OPCODE_REAL = 2'd1,
        LT_OPCODE_REAL = 2'd2,
        LE_OPCODE_REAL = 2'd3
    } cmp_op_t;

    // One extra bit keeps b +/- h inside the aligned range.
    localparam int GUARD_BITS = 1;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

    function automatic int min3(input int x, input int y, input int z);
        int m;
        m = (x < y) ? x : y;
        return (m < z) ? m : z;
    endfunction

endpackage

// File: rtl/comp_hyst_cond.sv
// Aligns a, b and hyst to a common fixed-point format and decodes set/clear
// conditions for the selected opcode against the band [b-h, b+h].
module comp_hyst_cond
    import comp_hyst_pkg::*;
#(
    parameter int a_width    = 18,
    parameter int a_exponent = -12,
    parameter int b_width    = 18,
    parameter int b_exponent = -12,
    parameter int h_width    = 18,
    parameter int h_exponent = -12
) (
    input  logic signed [a_width-1:0] a,
    input  logic signed [b_width-1:0] b,
    input  logic signed [h_width-1:0] hyst,
    input  logic [1:0]                opcode,
    output logic                      set,
    output logic                      clr
);

    // Finest LSB wins; coarser operands are shifted up to meet it.
    localparam int EXP_MIN = min3(a_exponent, b_exponent, h_exponent);
    localparam int SH_A    = a_exponent - EXP_MIN;
    localparam int SH_B    = b_exponent - EXP_MIN;
    localparam int SH_H    = h_exponent - EXP_MIN;
    localparam int W_AL    = max3(a_width + SH_A, b_width + SH_B, h_width + SH_H) + GUARD_BITS;

    logic signed [W_AL-1:0] a_al, b_al, hyst_al, h_al, hi, lo;

    assign a_al    = W_AL'(a)    <<< SH_A;
    assign b_al    = W_AL'(b)    <<< SH_B;
    assign hyst_al = W_AL'(hyst) <<< SH_H;
    assign h_al    = hyst_al[W_AL-1] ? '0 : hyst_al;
    assign hi      = b_al + h_al;
    assign lo      = b_al - h_al;

    always_comb begin
        set = (a_al > hi);
        clr = (a_al <= lo);
        case (opcode)
            GE_OPCODE_REAL: begin set = (a_al >= hi); clr = (a_al <  lo); end
            LT_OPCODE_REAL: begin set = (a_al <  lo); clr = (a_al >= hi); end
            LE_OPCODE_REAL: begin set = (a_al <= lo); clr = (a_al >  hi); end
            default: ;
        endcase
    end

endmodule

// File: rtl/comp_hyst_real.sv
// Registered comparator with hysteresis and debounce: c moves only after the
// new condition holds for deb_cycles consecutive enabled samples.
module comp_hyst_real
    import comp_hyst_pkg::*;
#(
    parameter int a_width    = 18,
    parameter int a_exponent = -12,
    parameter int b_width    = 18,
    parameter int b_exponent = -12,
    parameter int h_width    = 18,
    parameter int h_exponent = -12,
    parameter int deb_cycles = 1,
    parameter bit init       = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cke,
    input  logic signed [a_width-1:0] a,
    input  logic signed [b_width-1:0] b,
    input  logic signed [h_width-1:0] hyst,
    input  logic [1:0]                opcode,
    output logic                      c,
    output logic                      rise,
    output logic                      fall
);

    localparam int CNT_W = $clog2(deb_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(deb_cycles - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hyst_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       op_q;
    logic             set, clr, op_chg, c_nxt;

    comp_hyst_cond #(
        .a_width(a_width), .a_exponent(a_exponent),
        .b_width(b_width), .b_exponent(b_exponent),
        .h_width(h_width), .h_exponent(h_exponent)
    ) u_cond (
        .a(a), .b(b), .hyst(hyst), .opcode(opcode), .set(set), .clr(clr)
    );

    // op_q tracks the opcode of the previous enabled sample only.
    assign op_chg = (opcode != op_q);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_LOW: if (set) begin
                if (deb_cycles == 1) state_nxt = ST_HIGH;
                else begin state_nxt = ST_ARM_H; cnt_nxt = CNT_ONE; end
            end
            ST_ARM_H: begin
                if (op_chg || !set) begin state_nxt = ST_LOW; cnt_nxt = '0; end
                else if (cnt == CNT_LAST) begin state_nxt = ST_HIGH; cnt_nxt = '0; end
                else cnt_nxt = cnt + CNT_ONE;
            end
            ST_HIGH: if (clr) begin
                if (deb_cycles == 1) state_nxt = ST_LOW;
                else begin state_nxt = ST_ARM_L; cnt_nxt = CNT_ONE; end
            end
            ST_ARM_L: begin
                if (op_chg || !clr) begin state_nxt = ST_HIGH; cnt_nxt = '0; end
                else if (cnt == CNT_LAST) begin state_nxt = ST_LOW; cnt_nxt = '0; end
                else cnt_nxt = cnt + CNT_ONE;
            end
            default: begin state_nxt = ST_LOW; cnt_nxt = '0; end
        endcase
        c_nxt = (state_nxt == ST_HIGH) || (state_nxt == ST_ARM_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= init ? ST_HIGH : ST_LOW;
            cnt   <= '0;
            c     <= init;
            rise  <= 1'b0;
            fall  <= 1'b0;
            op_q  <= opcode;
        end else if (cke) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            c     <= c_nxt;
            rise  <= ~c & c_nxt;
            fall  <= c & ~c_nxt;
            op_q  <= opcode;
        end else begin
            rise  <= 1'b0;
            fall  <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && cke)
            assert (!$isunknown(opcode)) else $error("comp_hyst_real: unknown opcode, treated as GT");
    end
`endif

endmodule
